// File: rtl/rc_cpl_depacketizer_x8_if.sv
// rc_cpl_depacketizer_x8_if: AXI4-Stream bundle used on both sides of the
// x8 completion depacketizer. The input stream carries tuser and ignores
// tfirst/terr. The output stream carries tfirst/terr and drives tuser to zero.
interface rc_cpl_depacketizer_x8_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 85
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tfirst;
  logic                  terr;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata, tkeep, tlast, tuser, tfirst, terr, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tuser, tfirst, terr, tvalid,
    output tready
  );
endinterface

// File: rtl/rc_cpl_depacketizer_x8.sv
// rc_cpl_depacketizer_x8: strips the 3DW completion header from a 256-bit
// legacy-format RC completion stream. Header fields are held as sideband
// until the next header arrives. The payload is realigned so that payload
// DW0 appears on output DW0.
// The optional payload-length check is enabled by defining RC_CPL_LEN_CHECK_EN.
// This adds the len_err output port.
module rc_cpl_depacketizer_x8 #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic       user_clk,
  input  logic       user_reset,
  rc_cpl_depacketizer_x8_if.slave  s_axis,
  rc_cpl_depacketizer_x8_if.master m_axis,
  output logic [9:0]  hdr_len,
  output logic        hdr_with_data,
  output logic [11:0] hdr_bytecnt,
  output logic [2:0]  hdr_cmpstatus,
  output logic [15:0] hdr_cplid,
  output logic [6:0]  hdr_lowaddr,
  output logic [7:0]  hdr_tag,
  output logic [15:0] hdr_reqid,
  output logic        hdr_poisoned
`ifdef RC_CPL_LEN_CHECK_EN
  ,
  output logic        len_err
`endif
);

  localparam int HDR_BITS  = 96;
  localparam int HDR_BYTES = 12;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    FLUSH
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-HDR_BITS-1:0]  carry_data;
  logic [KEEP_WIDTH-HDR_BYTES-1:0] carry_keep;
  logic                            err_acc;
  logic                            first_pend;

  logic [DATA_WIDTH-1:0] m_data;
  logic [KEEP_WIDTH-1:0] m_keep;
  logic                  m_last;
  logic                  m_valid;
  logic                  s_ready;
  logic                  m_err;
  logic                  hdr_accept;
  logic                  body_xfer;
  logic                  out_xfer;

  // Only the poison and discontinue bits of tuser matter here.
  // The input-side tfirst/terr are not used either.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis.tuser[84:2], s_axis.tfirst, s_axis.terr};

  assign hdr_accept = (state == IDLE) && s_axis.tvalid;
  assign body_xfer  = (state == BODY) && s_axis.tvalid && m_axis.tready;
  assign out_xfer   = m_valid && m_axis.tready;

  // Next-state decode and realigned output beat.
  // Body beats pass straight through, combining input DW0-2 with the carried DW3-7.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_keep     = '0;
    m_last     = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_axis.tvalid) begin
          state_next = s_axis.tlast ? FLUSH : BODY;
        end
      end
      BODY: begin
        s_ready = m_axis.tready;
        m_valid = s_axis.tvalid;
        m_data  = {s_axis.tdata[HDR_BITS-1:0], carry_data};
        m_keep  = {s_axis.tkeep[HDR_BYTES-1:0], carry_keep};
        m_last  = s_axis.tlast && (s_axis.tkeep[KEEP_WIDTH-1:HDR_BYTES] == '0);
        if (body_xfer && s_axis.tlast) begin
          state_next = m_last ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        m_valid = 1'b1;
        m_data  = {{HDR_BITS{1'b0}}, carry_data};
        m_keep  = {{HDR_BYTES{1'b0}}, carry_keep};
        m_last  = 1'b1;
        if (m_axis.tready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The error flag covers every beat seen so far, including the beat now in BODY.
  // It is forced low in IDLE so that a stale flag never shows between packets.
  always_comb begin
    m_err = 1'b0;
    if (state != IDLE) begin
      m_err = err_acc || ((state == BODY) && s_axis.tuser[0]);
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_data;
  assign m_axis.tkeep  = m_keep;
  assign m_axis.tlast  = m_last;
  assign m_axis.tfirst = m_valid && first_pend;
  assign m_axis.terr   = m_err;
  assign m_axis.tuser  = '0;

  // State register, header capture and payload carry.
  // A reset mid-packet drops the carry, so the next accepted beat is decoded as a header.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state         <= IDLE;
      carry_data    <= '0;
      carry_keep    <= '0;
      err_acc       <= 1'b0;
      first_pend    <= 1'b0;
      hdr_len       <= '0;
      hdr_with_data <= 1'b0;
      hdr_bytecnt   <= '0;
      hdr_cmpstatus <= '0;
      hdr_cplid     <= '0;
      hdr_lowaddr   <= '0;
      hdr_tag       <= '0;
      hdr_reqid     <= '0;
      hdr_poisoned  <= 1'b0;
    end else begin
      state <= state_next;
      if (hdr_accept) begin
        hdr_len       <= s_axis.tdata[9:0];
        hdr_with_data <= s_axis.tdata[30];
        hdr_bytecnt   <= s_axis.tdata[43:32];
        hdr_cmpstatus <= s_axis.tdata[47:45];
        hdr_cplid     <= s_axis.tdata[63:48];
        hdr_lowaddr   <= s_axis.tdata[70:64];
        hdr_tag       <= s_axis.tdata[79:72];
        hdr_reqid     <= s_axis.tdata[95:80];
        hdr_poisoned  <= s_axis.tuser[1];
        carry_data    <= s_axis.tdata[DATA_WIDTH-1:HDR_BITS];
        carry_keep    <= s_axis.tkeep[KEEP_WIDTH-1:HDR_BYTES];
        err_acc       <= s_axis.tuser[0];
        first_pend    <= 1'b1;
      end else if (body_xfer) begin
        carry_data <= s_axis.tdata[DATA_WIDTH-1:HDR_BITS];
        carry_keep <= s_axis.tkeep[KEEP_WIDTH-1:HDR_BYTES];
        err_acc    <= err_acc | s_axis.tuser[0];
        first_pend <= 1'b0;
      end
    end
  end

`ifdef RC_CPL_LEN_CHECK_EN
  logic [5:0] keep_ones;
  logic [9:0] len_count;
  logic [9:0] len_count_sum;

  // Count the DWords delivered on the current output beat.
  // Keeps are DW-granular, so the number of set bits divided by four gives the DWord count.
  always_comb begin
    keep_ones = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_ones = keep_ones + {5'd0, m_keep[i]};
    end
  end

  assign len_count_sum = len_count + {6'd0, keep_ones[5:2]};

  // Running payload count, compared against the header on the tlast transfer.
  // The count is 10 bits wide, so a length field of 0 matches a 1024-DW payload.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      len_count <= '0;
      len_err   <= 1'b0;
    end else begin
      len_err <= out_xfer && m_last && hdr_with_data && (len_count_sum != hdr_len);
      if (hdr_accept) begin
        len_count <= '0;
      end else if (out_xfer) begin
        len_count <= len_count_sum;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rc_cpl_depacketizer_x8.sv
// tb_rc_cpl_depacketizer_x8: directed completions driven through the depacketizer.
// A queue-based payload model predicts each output beat. The model chunks each
// TLP's payload DWs into groups of eight.
// Define RC_CPL_LEN_CHECK_EN to also check the len_err pulse.
`timescale 1ns/1ps
module tb_rc_cpl_depacketizer_x8;

  typedef struct packed {
    logic [9:0]  len;
    logic        with_data;
    logic [11:0] bytecnt;
    logic [2:0]  cmpstatus;
    logic [15:0] cplid;
    logic [6:0]  lowaddr;
    logic [7:0]  tag;
    logic [15:0] reqid;
    logic        poisoned;
  } hdr_t;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic         first;
    logic         err;
    logic         len_err;
    hdr_t         hdr;
  } beat_t;

  logic user_clk = 1'b0;
  logic user_reset = 1'b1;
  logic toggle_en = 1'b0;

  logic [9:0]  hdr_len;
  logic        hdr_with_data;
  logic [11:0] hdr_bytecnt;
  logic [2:0]  hdr_cmpstatus;
  logic [15:0] hdr_cplid;
  logic [6:0]  hdr_lowaddr;
  logic [7:0]  hdr_tag;
  logic [15:0] hdr_reqid;
  logic        hdr_poisoned;
`ifdef RC_CPL_LEN_CHECK_EN
  logic        len_err;
`endif

  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [31:0] pay_q[$];
  int          total_checks = 0;
  int          bad_checks = 0;

  rc_cpl_depacketizer_x8_if s_if ();
  rc_cpl_depacketizer_x8_if m_if ();

  always #5 user_clk = ~user_clk;

  rc_cpl_depacketizer_x8 dut (
    .user_clk      (user_clk),
    .user_reset    (user_reset),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .hdr_len       (hdr_len),
    .hdr_with_data (hdr_with_data),
    .hdr_bytecnt   (hdr_bytecnt),
    .hdr_cmpstatus (hdr_cmpstatus),
    .hdr_cplid     (hdr_cplid),
    .hdr_lowaddr   (hdr_lowaddr),
    .hdr_tag       (hdr_tag),
    .hdr_reqid     (hdr_reqid),
    .hdr_poisoned  (hdr_poisoned)
`ifdef RC_CPL_LEN_CHECK_EN
    ,
    .len_err       (len_err)
`endif
  );

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] byte_mask(input logic [31:0] k);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic hdr_t make_hdr(input logic [9:0] len, input logic wd, input logic [7:0] tag,
                                    input logic pois);
    hdr_t h;
    h.len       = len;
    h.with_data = wd;
    h.bytecnt   = wd ? {len, 2'b00} : 12'd0;
    h.cmpstatus = 3'b010;
    h.cplid     = 16'h0100 | {8'd0, tag};
    h.lowaddr   = tag[6:0];
    h.tag       = tag;
    h.reqid     = 16'hBEEF ^ {tag, tag};
    h.poisoned  = pois;
    return h;
  endfunction

  task automatic fill_pay(input int n, input logic [31:0] base);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(base + 32'(i));
  endtask

  // Build the input beats for one TLP and push the predicted output beats.
  // If abort_at >= 0, reset is asserted while that beat is presented.
  task automatic applyStimulus(input hdr_t h, input int err_beat, input int abort_at);
    logic [31:0]  dws[$];
    logic [255:0] data;
    logic [31:0]  keep;
    logic [63:0]  kwide;
    beat_t        e;
    int nbeats, npay, nchunks, nemit, m, guard;
    logic accepted, any_err;
    dws.delete();
    dws.push_back({1'b0, h.with_data, 20'd0, h.len});
    dws.push_back({h.cplid, h.cmpstatus, 1'b0, h.bytecnt});
    dws.push_back({h.reqid, h.tag, 1'b0, h.lowaddr});
    foreach (pay_q[i]) dws.push_back(pay_q[i]);
    nbeats  = (dws.size() + 7) / 8;
    npay    = pay_q.size();
    nchunks = (npay == 0) ? 1 : (npay + 7) / 8;
    any_err = (err_beat >= 0) && (err_beat < nbeats);
    nemit   = (abort_at >= 0) ? abort_at - 1 : nchunks;
    for (int c = 0; c < nemit; c++) begin
      m = npay - 8 * c;
      if (m > 8) m = 8;
      e.data = '0;
      for (int i = 0; i < m; i++) e.data[32*i +: 32] = pay_q[8*c + i];
      kwide     = (64'd1 << (4 * m)) - 64'd1;
      e.keep    = kwide[31:0];
      e.first   = (c == 0);
      e.last    = (c == nchunks - 1);
      e.err     = any_err;
      e.len_err = h.with_data && ((npay % 1024) != int'(h.len));
      e.hdr     = h;
      exp_q.push_back(e);
    end
    for (int b = 0; b < nbeats; b++) begin
      data = '0;
      keep = '0;
      for (int i = 0; i < 8; i++) begin
        if (8*b + i < dws.size()) begin
          data[32*i +: 32] = dws[8*b + i];
          keep[4*i +: 4]   = 4'hF;
        end
      end
      s_if.tdata    = data;
      s_if.tkeep    = keep;
      s_if.tlast    = (b == nbeats - 1);
      s_if.tuser    = '0;
      s_if.tuser[1] = (b == 0) && h.poisoned;
      s_if.tuser[0] = (b == err_beat);
      s_if.tvalid   = 1'b1;
      if (b == abort_at) begin
        user_reset = 1'b1;
        @(negedge user_clk);
        user_reset  = 1'b0;
        s_if.tvalid = 1'b0;
        return;
      end
      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 200) begin
        #1;
        accepted = s_if.tready;
        if (b > 0) checkOutput("ready_mirror", 256'(s_if.tready), 256'(m_if.tready));
        @(negedge user_clk);
        guard++;
      end
      if (!accepted) checkOutput("beat_accept_timeout", 256'(0), 256'(1));
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge user_clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", 256'(exp_q.size()), 256'(0));
      exp_q.delete();
    end
    repeat (3) @(negedge user_clk);
  endtask

  // Output ready: either held high, or toggled every cycle for the back-pressure runs.
  initial begin
    forever begin
      @(negedge user_clk);
      if (toggle_en) m_if.tready = ~m_if.tready;
      else m_if.tready = 1'b1;
    end
  end

  // Compare every output transfer against the model.
  // Also check that held beats stay stable and that len_err pulses exactly when predicted.
  initial begin
    beat_t g, e, prev;
    logic stall_prev = 1'b0;
    logic len_pend = 1'b0;
    prev = '0;
    forever begin
      @(negedge user_clk);
      #2;
      if (user_reset) begin
        stall_prev = 1'b0;
        len_pend   = 1'b0;
      end else begin
        g.data    = m_if.tdata;
        g.keep    = m_if.tkeep;
        g.last    = m_if.tlast;
        g.first   = m_if.tfirst;
        g.err     = m_if.terr;
        g.len_err = 1'b0;
        g.hdr     = {hdr_len, hdr_with_data, hdr_bytecnt, hdr_cmpstatus, hdr_cplid,
                     hdr_lowaddr, hdr_tag, hdr_reqid, hdr_poisoned};
`ifdef RC_CPL_LEN_CHECK_EN
        checkOutput("len_err", 256'(len_err), 256'(len_pend));
`endif
        len_pend = 1'b0;
        if (stall_prev) begin
          checkOutput("stall_valid", 256'(m_if.tvalid), 256'(1));
          checkOutput("stall_data", g.data, prev.data);
          checkOutput("stall_ctrl", {g.keep, g.last, g.first}, {prev.keep, prev.last, prev.first});
        end
        if (m_if.tvalid && m_if.tready) begin
          got_q.push_back(g);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", 256'(1), 256'(0));
          end else begin
            e = exp_q.pop_front();
            checkOutput("data", g.data & byte_mask(e.keep), e.data & byte_mask(e.keep));
            checkOutput("keep", 256'(g.keep), 256'(e.keep));
            checkOutput("last", 256'(g.last), 256'(e.last));
            checkOutput("first", 256'(g.first), 256'(e.first));
            checkOutput("hdr_fields", 256'(g.hdr), 256'(e.hdr));
            if (e.last) begin
              checkOutput("terr", 256'(g.err), 256'(e.err));
              len_pend = e.len_err;
            end
          end
        end
        stall_prev = m_if.tvalid && !m_if.tready;
        prev = g;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    hdr_t h;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    s_if.tfirst = 1'b0;
    s_if.terr   = 1'b0;
    s_if.tvalid = 1'b0;
    repeat (3) @(negedge user_clk);
    user_reset = 1'b0;
    #2;
    checkOutput("rst_tvalid", 256'(m_if.tvalid), 256'(0));
    checkOutput("rst_tfirst", 256'(m_if.tfirst), 256'(0));
    checkOutput("rst_terr", 256'(m_if.terr), 256'(0));
    checkOutput("rst_s_ready", 256'(s_if.tready), 256'(1));
    checkOutput("rst_hdr", 256'({hdr_len, hdr_with_data, hdr_bytecnt, hdr_cmpstatus, hdr_cplid,
                                 hdr_lowaddr, hdr_tag, hdr_reqid, hdr_poisoned}), 256'(0));
    @(negedge user_clk);

    $display("[TB] single-beat completion, len=1");
    h = make_hdr(10'd1, 1'b1, 8'h11, 1'b0);
    pay_q.delete();
    pay_q.push_back(32'hA5A5A5A5);
    got_q.delete();
    applyStimulus(h, -1, -1);
    wait_drain();
    checkOutput("t1_count", 256'(got_q.size()), 256'(1));
    if (got_q.size() >= 1) begin
      checkOutput("t1_dw0", 256'(got_q[0].data[31:0]), 256'(32'hA5A5A5A5));
      checkOutput("t1_keep", 256'(got_q[0].keep), 256'(32'h0000000F));
      checkOutput("t1_first_last", 256'({got_q[0].first, got_q[0].last}), 256'(2'b11));
    end

    $display("[TB] 8DW completion");
    h = make_hdr(10'd8, 1'b1, 8'h21, 1'b0);
    fill_pay(8, 32'h80000000);
    got_q.delete();
    applyStimulus(h, -1, -1);
    wait_drain();
    checkOutput("t2_count", 256'(got_q.size()), 256'(1));
    if (got_q.size() >= 1) begin
      checkOutput("t2_keep", 256'(got_q[0].keep), 256'(32'hFFFFFFFF));
      checkOutput("t2_dw0", 256'(got_q[0].data[31:0]), 256'(32'h80000000));
      checkOutput("t2_dw7", 256'(got_q[0].data[255:224]), 256'(32'h80000007));
      checkOutput("t2_last", 256'(got_q[0].last), 256'(1));
    end

    $display("[TB] 6DW completion");
    h = make_hdr(10'd6, 1'b1, 8'h22, 1'b0);
    fill_pay(6, 32'h60000000);
    got_q.delete();
    applyStimulus(h, -1, -1);
    wait_drain();
    checkOutput("t3_count", 256'(got_q.size()), 256'(1));
    if (got_q.size() >= 1) checkOutput("t3_keep", 256'(got_q[0].keep), 256'(32'h00FFFFFF));

    $display("[TB] 19DW completion ending in a flush beat");
    h = make_hdr(10'd19, 1'b1, 8'h23, 1'b0);
    fill_pay(19, 32'h19000000);
    got_q.delete();
    applyStimulus(h, -1, -1);
    wait_drain();
    checkOutput("t4_count", 256'(got_q.size()), 256'(3));
    if (got_q.size() >= 3) begin
      checkOutput("t4_mid_last", 256'(got_q[1].last), 256'(0));
      checkOutput("t4_last_keep", 256'(got_q[2].keep), 256'(32'h00000FFF));
    end

    $display("[TB] zero-data completion");
    h = make_hdr(10'd0, 1'b0, 8'h3C, 1'b0);
    pay_q.delete();
    got_q.delete();
    applyStimulus(h, -1, -1);
    wait_drain();
    checkOutput("t5_count", 256'(got_q.size()), 256'(1));
    if (got_q.size() >= 1) begin
      checkOutput("t5_keep", 256'(got_q[0].keep), 256'(0));
      checkOutput("t5_last", 256'(got_q[0].last), 256'(1));
      checkOutput("t5_tag_wd", 256'({got_q[0].hdr.tag, got_q[0].hdr.with_data}), 256'({8'h3C, 1'b0}));
    end

    $display("[TB] discontinue on middle beat, poisoned");
    h = make_hdr(10'd16, 1'b1, 8'h24, 1'b1);
    fill_pay(16, 32'hE0000000);
    got_q.delete();
    applyStimulus(h, 1, -1);
    wait_drain();
    checkOutput("t6_count", 256'(got_q.size()), 256'(2));
    if (got_q.size() >= 2) begin
      checkOutput("t6_terr_last", 256'({got_q[1].err, got_q[1].last}), 256'(2'b11));
      checkOutput("t6_poisoned", 256'(got_q[0].hdr.poisoned), 256'(1));
    end

    $display("[TB] back-pressure on 32DW and 19DW completions");
    toggle_en = 1'b1;
    h = make_hdr(10'd32, 1'b1, 8'h25, 1'b0);
    fill_pay(32, 32'h32000000);
    got_q.delete();
    applyStimulus(h, -1, -1);
    wait_drain();
    checkOutput("t7_count", 256'(got_q.size()), 256'(4));
    if (got_q.size() >= 4) checkOutput("t7_last_keep", 256'(got_q[3].keep), 256'(32'hFFFFFFFF));
    h = make_hdr(10'd19, 1'b1, 8'h26, 1'b0);
    fill_pay(19, 32'h91000000);
    got_q.delete();
    applyStimulus(h, -1, -1);
    wait_drain();
    checkOutput("t7b_count", 256'(got_q.size()), 256'(3));
    toggle_en = 1'b0;
    @(negedge user_clk);

    $display("[TB] reset in the middle of a TLP");
    h = make_hdr(10'd32, 1'b1, 8'h55, 1'b0);
    fill_pay(32, 32'h55000000);
    got_q.delete();
    applyStimulus(h, -1, 2);
    #2;
    checkOutput("abort_tvalid", 256'(m_if.tvalid), 256'(0));
    checkOutput("abort_s_ready", 256'(s_if.tready), 256'(1));
    @(negedge user_clk);
    h = make_hdr(10'd6, 1'b1, 8'h77, 1'b0);
    fill_pay(6, 32'h77000000);
    got_q.delete();
    applyStimulus(h, -1, -1);
    wait_drain();
    checkOutput("t8_count", 256'(got_q.size()), 256'(1));
    if (got_q.size() >= 1) checkOutput("t8_tag", 256'(got_q[0].hdr.tag), 256'(8'h77));

    $display("[TB] length field vs delivered payload");
    h = make_hdr(10'd4, 1'b1, 8'h41, 1'b0);
    fill_pay(3, 32'h40000000);
    applyStimulus(h, -1, -1);
    wait_drain();
    h = make_hdr(10'd4, 1'b1, 8'h42, 1'b0);
    fill_pay(4, 32'h44000000);
    applyStimulus(h, -1, -1);
    wait_drain();

    checkOutput("exp_queue_empty", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
